// File: rtl/mem_arbiter.sv
// mem_arbiter: byte-serial bus controller arbitrating instruction fetch and data access
//   clk, rst (sync, active high), rdy (low freezes the block)
//   if_req/if_addr/if_flush -> if_done/if_inst : 4-byte instruction fetch
//   dm_req/dm_we/dm_addr/dm_wdata/dm_size/dm_signed -> dm_done/dm_rdata : data load/store
//   mem_din/mem_dout/mem_a/mem_wr : 8-bit external bus, read data one cycle after address
//   MEMARB_IF_ABORT_EN : when defined, if_flush aborts an in-flight fetch
module mem_arbiter #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_done,
  output logic [31:0]       if_inst,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [31:0]       dm_wdata,
  input  logic [1:0]        dm_size,
  input  logic              dm_signed,
  output logic              dm_done,
  output logic [31:0]       dm_rdata,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr
);
  typedef enum logic [1:0] {IDLE, RD, WR} state_t;
  state_t st, st_n;
  logic [ADDR_W-1:0] base, a_q;
  logic [31:0] acc, wd, asm_w, ext_w;
  logic [2:0] step, n;
  logic [1:0] k;
  logic is_if, wr_q, sg, flush_en;
  logic idle_ok, go_dm, go_if, abort, cap, fin_rd, fin_wr;
`ifdef MEMARB_IF_ABORT_EN
  assign flush_en = if_flush;
`else
  logic unused_flush;
  assign unused_flush = if_flush;
  assign flush_en = 1'b0;
`endif
  assign idle_ok = st == IDLE && !if_done && !dm_done;
  assign go_dm = idle_ok && dm_req;
  assign go_if = idle_ok && !dm_req && if_req && !flush_en;
  assign abort = st == RD && is_if && flush_en;
  // step counts rdy-high edges since acceptance; from step 1 on a byte is due each edge
  assign cap = st == RD && step != 3'd0;
  assign fin_rd = st == RD && step == n;
  assign fin_wr = st == WR && step == n - 3'd1;
  assign k = step[1:0] - 2'd1;
  // while frozen, re-present the address whose byte is due so mem_din still holds it on resume
  assign mem_a = (!rdy && cap) ? base + ADDR_W'(k) : a_q;
  assign mem_wr = wr_q && rdy;
  always_comb begin
    asm_w = acc;
    asm_w[{k, 3'b000} +: 8] = mem_din;
    ext_w = n == 3'd1 ? {{24{sg & asm_w[7]}}, asm_w[7:0]} :
            n == 3'd2 ? {{16{sg & asm_w[15]}}, asm_w[15:0]} : asm_w;
    st_n = go_dm ? (dm_we ? WR : RD) : go_if ? RD : (abort || fin_rd || fin_wr) ? IDLE : st;
  end
  always_ff @(posedge clk)
    if (rst) st <= IDLE;
    else if (rdy) st <= st_n;
  always_ff @(posedge clk) begin
    if (rst) begin
      base <= '0;
      a_q <= '0;
      acc <= '0;
      wd <= '0;
      step <= '0;
      n <= '0;
      is_if <= 1'b0;
      wr_q <= 1'b0;
      sg <= 1'b0;
      mem_dout <= '0;
      if_done <= 1'b0;
      dm_done <= 1'b0;
      if_inst <= '0;
      dm_rdata <= '0;
    end else if (rdy) begin
      if_done <= 1'b0;
      dm_done <= 1'b0;
      if (go_dm || go_if) begin
        base <= go_dm ? dm_addr : if_addr;
        a_q <= go_dm ? dm_addr : if_addr;
        step <= '0;
        is_if <= go_if;
        n <= go_if ? 3'd4 : dm_size == 2'd0 ? 3'd1 : dm_size == 2'd1 ? 3'd2 : 3'd4;
        wr_q <= go_dm && dm_we;
        sg <= dm_signed;
        wd <= dm_wdata;
        mem_dout <= (go_dm && dm_we) ? dm_wdata[7:0] : 8'd0;
      end else if (abort) begin
        a_q <= '0;
      end else if (st == RD) begin
        if (cap) acc <= asm_w;
        if (fin_rd) begin
          a_q <= '0;
          if (is_if) begin
            if_inst <= asm_w;
            if_done <= 1'b1;
          end else begin
            dm_rdata <= ext_w;
            dm_done <= 1'b1;
          end
        end else begin
          step <= step + 3'd1;
          if (step + 3'd1 < n) a_q <= base + ADDR_W'(step) + ADDR_W'(1);
        end
      end else if (st == WR) begin
        if (fin_wr) begin
          a_q <= '0;
          wr_q <= 1'b0;
          mem_dout <= '0;
          dm_done <= 1'b1;
        end else begin
          step <= step + 3'd1;
          a_q <= base + ADDR_W'(step) + ADDR_W'(1);
          mem_dout <= wd[{step[1:0] + 2'd1, 3'b000} +: 8];
        end
      end
    end
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Byte-serial memory-bus controller between the CPU pipeline and the 8-bit external RAM/IO bus.
- Arbitrates two requesters: instruction fetch (4-byte read) and the MEM stage (1/2/4-byte load or store).
- Serialises each access into byte cycles; a read returns data one cycle after its address.
- Assembles little-endian words and returns them with a one-cycle done pulse.

Parameters:
ADDR_W, 32, width of all address ports and of mem_a.

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
rdy  in  1  ready; low freezes the block
if_req  in  1  fetch request, held until if_done
if_addr  in  ADDR_W  fetch address
if_flush  in  1  fetch abort (used only with the macro)
if_done  out  1  one-cycle pulse; if_inst valid in this cycle
if_inst  out  32  fetched instruction
dm_req  in  1  data request, held until dm_done
dm_we  in  1  1=store, 0=load
dm_addr  in  ADDR_W  data address
dm_wdata  in  32  store data (low bytes used)
dm_size  in  2  00 byte, 01 half, 10/11 word
dm_signed  in  1  sign-extend loads
dm_done  out  1  one-cycle pulse; dm_rdata valid in this cycle
dm_rdata  out  32  load result, extended to 32 bits
mem_din  in  8  bus read data
mem_dout  out  8  bus write data
mem_a  out  ADDR_W  bus address
mem_wr  out  1  1=write cycle

Behaviour:
- Reset (synchronous, rst=1 at posedge): state IDLE. All outputs 0: mem_a, mem_dout, mem_wr, if_done, dm_done, if_inst, dm_rdata.
- States: IDLE, RD, WR.
  - IDLE accepts a request only when if_done=0 and dm_done=0.
  - If both requests are high, dm wins; if_req is simply held and is served next.
- N = 1, 2 or 4 bytes (fetch is always 4). Byte k is at address addr+k, where 0 ≤ k < N, with ADDR_W wrap.
- Acceptance at posedge t → first bus cycle is t+1 (outputs registered).
- RD:
  - mem_a = addr+k in cycles t+1..t+N, with mem_wr=0.
  - The byte for address cycle c is captured from mem_din at the end of cycle c+1.
  - Byte k goes to bits [8k+7:8k].
  - done pulses in cycle t+N+2, and the state returns to IDLE in that cycle.
  - Fetch latency is 6 cycles from acceptance to done.
- WR:
  - mem_a = addr+k, mem_dout = dm_wdata[8k+7:8k], mem_wr=1 in cycles t+1..t+N.
  - dm_done pulses in cycle t+N+1.
- Load extension: dm_signed=1 sign-extends from bit 8N-1; dm_signed=0 zero-extends. dm_rdata and if_inst hold their last value after done.
- Idle bus: mem_a=0, mem_wr=0, mem_dout=0.
- Requesters deassert req in the done cycle. Any req still high in the done cycle is ignored for that cycle.
- rdy=0:
  - No register updates and no captures; mem_wr is gated to 0.
  - mem_a re-presents the address whose byte is awaiting capture, if any; otherwise it holds.
  - On the first rdy=1 cycle, mem_din holds that byte. The block captures it and continues, so a freeze of any length is lossless.
- IO addresses (mem_a[17:16]==2'b11) get no special timing. A 1-byte store to 0x30000 produces exactly one mem_wr cycle, even across rdy freezes.
- rst mid-transfer: abort immediately and return to IDLE with no done pulse.

Optional Feature:
- MEMARB_IF_ABORT_EN defined:
  - if_flush=1 while a fetch is in RD aborts it at that posedge: state IDLE, no if_done, if_inst unchanged.
  - if_flush in the acceptance cycle cancels acceptance.
  - A dm request may be accepted the next cycle.
- Undefined: if_flush is ignored and the fetch completes. The fetch unit discards the stale if_done.

Test Plan:
- Reset, then if_req=1, if_addr=0x100, RAM[0x100..0x103]=13 05 10 00 → mem_a 0x100..0x103 in cycles 1–4; if_done in cycle 6; if_inst=0x00100513.
- if_req and dm_req both high at the same posedge; dm is a load of byte 0x200, RAM=0x80, dm_signed=1 → dm served first; dm_rdata=0xFFFFFF80, dm_done in cycle 3; fetch accepted the cycle after dm_done; if_done 6 cycles later.
- Store word 0xDEADBEEF to 0x400 → mem_wr=1 for 4 cycles with mem_dout EF, BE, AD, DE at 0x400..0x403; dm_done in cycle 5; no read cycles.
- Fetch at 0x0 with rdy=0 for 3 cycles during the capture of byte 1 → if_inst is correct, if_done is delayed by exactly 3 cycles, and mem_wr stays 0 throughout.
- Byte store 0x41 to 0x30000 with rdy toggling 1,0,0,1 → exactly one mem_wr=1 cycle at 0x30000.
- With MEMARB_IF_ABORT_EN: if_flush=1 in cycle 3 of a fetch → no if_done; a pending dm load is accepted in the next cycle and completes normally.
